// File: rtl/ser_tx_bc.sv
// ser_tx_bc -- serial transmit stage of the PHY.
//
// This block accepts bytes through a valid/ready handshake and stores them in
// a 4-entry FIFO. It shifts each byte out MSB-first, one bit per clk_32f cycle.
// After reset it sends SYNC_COMMAS COMMA symbols so the receiver can find the
// byte boundaries. After that it sends queued bytes, or IDLE_CODE when the
// FIFO is empty.
//
// Optional feature (compile-time macro SER_RESYNC_EN):
//   When defined, the block counts cycles in RUN with rx_active low. After 8
//   consecutive low cycles it re-enters SYNC at the next byte boundary. The
//   FIFO contents are kept.
//   When undefined, rx_active is ignored.
//
// Ports:
//   clk_32f      in   bit clock; all state changes on the rising edge
//   reset_L      in   asynchronous active-low reset
//   data_in[7:0] in   byte to transmit
//   valid_in     in   data_in is valid
//   ready_out    out  a byte is accepted this cycle if valid_in is high
//   rx_active    in   far-end receiver in sync (used only with SER_RESYNC_EN)
//   data_out     out  serial bit stream (shift register MSB)
//   byte_strobe  out  high while data_out carries bit 0 of a byte
//   state_out    out  0=RESET, 1=SYNC, 2=RUN
`timescale 1ns/1ps
module ser_tx_bc #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter logic [7:0] IDLE_CODE   = 8'h7C,
  parameter int         SYNC_COMMAS = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       rx_active,
  output logic       data_out,
  output logic       byte_strobe,
  output logic [1:0] state_out
);

  localparam int SCW = (SYNC_COMMAS < 1) ? 1 : $clog2(SYNC_COMMAS + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(SYNC_COMMAS);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [7:0]     shift;
  logic [2:0]     bit_cnt;
  logic [SCW-1:0] sync_cnt, sync_nx;
  logic [7:0]     load_sym;
  logic           load, pop, push;
  logic           resync_flag;

  logic [7:0]     mem [4];
  logic [1:0]     rd_ptr, wr_ptr;
  logic [2:0]     count;

  assign ready_out = (state != ST_RESET) && (count < 3'd4);
  assign push      = valid_in && ready_out;
  assign data_out  = shift[7];
  assign state_out = state;

  // Symbol selection at each byte boundary. In RESET every edge is a load edge,
  // so the first edge after reset loads the first comma.
  always_comb begin
    state_nx = state;
    sync_nx  = sync_cnt;
    load_sym = IDLE_CODE;
    pop      = 1'b0;
    load     = (state == ST_RESET) || (bit_cnt == 3'd7);
    if (load) begin
      if (state == ST_RESET) begin
        load_sym = COMMA;
        state_nx = ST_SYNC;
        sync_nx  = SCW'(1);
      end else if (resync_flag) begin
        load_sym = COMMA;
        state_nx = ST_SYNC;
        sync_nx  = SCW'(1);
      end else if ((state == ST_SYNC) && (sync_cnt < SC_LAST)) begin
        load_sym = COMMA;
        sync_nx  = sync_cnt + SCW'(1);
      end else begin
        // Last comma done, or already in RUN: send the FIFO head or idle.
        // A byte pushed on this same edge is not yet in count.
        state_nx = ST_RUN;
        if (count != 3'd0) begin
          load_sym = mem[rd_ptr];
          pop      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state       <= ST_RESET;
      shift       <= 8'd0;
      bit_cnt     <= 3'd0;
      sync_cnt    <= '0;
      byte_strobe <= 1'b0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      count       <= 3'd0;
    end else begin
      state    <= state_nx;
      sync_cnt <= sync_nx;
      if (load) begin
        shift   <= load_sym;
        bit_cnt <= 3'd0;
      end else begin
        shift   <= {shift[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      // Registered strobe: high in the cycle where bit_cnt becomes 7.
      byte_strobe <= !load && (bit_cnt == 3'd6);
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage. Reset does not clear it; count alone decides validity.
  always_ff @(posedge clk_32f) begin
    if (push) mem[wr_ptr] <= data_in;
  end

`ifdef SER_RESYNC_EN
  logic [3:0] low_cnt;

  // Counts consecutive rx_active-low cycles in RUN. The count saturates at 8
  // and then raises the flag. The next load edge uses the flag and clears it.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      low_cnt     <= 4'd0;
      resync_flag <= 1'b0;
    end else if (load && resync_flag) begin
      low_cnt     <= 4'd0;
      resync_flag <= 1'b0;
    end else if (state == ST_RUN) begin
      if (rx_active) begin
        low_cnt <= 4'd0;
      end else if (low_cnt != 4'd8) begin
        low_cnt <= low_cnt + 4'd1;
        if (low_cnt == 4'd7) resync_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_rx_active;
  assign unused_rx_active = rx_active;
  assign resync_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_ser_tx_bc.sv
// Testbench for ser_tx_bc. A symbol-level reference model (current symbol,
// bit position, byte queue) predicts data_out, byte_strobe, ready_out and
// state_out every cycle. Directed phases cover the startup sequence, pushes
// during SYNC, filling the FIFO, a push on a load edge, a mid-byte reset and
// rx_active dropouts. A long randomized phase follows.
`timescale 1ns/1ps
module tb_ser_tx_bc;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE  = 8'h7C;
  localparam int         NSYNC = 4;

  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       rx_active;
  logic       data_out;
  logic       byte_strobe;
  logic [1:0] state_out;

  ser_tx_bc dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .rx_active  (rx_active),
    .data_out   (data_out),
    .byte_strobe(byte_strobe),
    .state_out  (state_out)
  );

  always #5 clk_32f = ~clk_32f;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_st;
  int         m_sc;
  int         m_pos;
  int         m_low;
  bit         m_flag;
  bit         m_acc;
  logic [7:0] m_sym;
  logic [7:0] q[$];

  // stimulus control
  logic [7:0] dq[$];
  int         p_valid   = 0;
  int         p_burst   = 0;
  int         rx_low_left = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sc = 0; m_pos = 0; m_low = 0; m_flag = 0; m_acc = 0;
    m_sym = 8'h00;
    q.delete();
  endtask

  // One rising edge of the symbol-level model, using the inputs present at that edge.
  task automatic model_edge();
    bit push, load, take;
    int old_st;
    push   = valid_in && (m_st != 0) && (q.size() < 4);
    load   = (m_st == 0) || (m_pos == 7);
    old_st = m_st;
    take   = 0;
`ifdef SER_RESYNC_EN
    take = load && m_flag;
`endif
    if (load) begin
      if (m_st == 0) begin
        m_sym = COMMA; m_st = 1; m_sc = 1;
      end else if (take) begin
        m_sym = COMMA; m_st = 1; m_sc = 1;
      end else if (m_st == 1 && m_sc < NSYNC) begin
        m_sym = COMMA; m_sc++;
      end else begin
        m_st  = 2;
        m_sym = (q.size() > 0) ? q.pop_front() : IDLE;
      end
      m_pos = 0;
    end else begin
      m_pos++;
    end
    if (push) q.push_back(data_in);
    m_acc = push;
`ifdef SER_RESYNC_EN
    if (take) begin
      m_low = 0; m_flag = 0;
    end else if (old_st == 2) begin
      if (rx_active) m_low = 0;
      else if (m_low < 8) begin
        m_low++;
        if (m_low == 8) m_flag = 1;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    logic [7:0] s;
    s = m_sym;
    chk("data_out", {7'd0, data_out}, {7'd0, s[7 - m_pos]});
    chk("byte_strobe", {7'd0, byte_strobe}, {7'd0, (m_pos == 7)});
    chk("ready_out", {7'd0, ready_out}, {7'd0, (m_st != 0 && q.size() < 4)});
    chk("state_out", {6'd0, state_out}, 8'(m_st));
  endtask

  task automatic step();
    @(posedge clk_32f);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Choose the inputs for the next edge. A byte that was offered but not
  // accepted stays on data_in until it is accepted.
  task automatic drive_next();
    if (!(valid_in && !m_acc)) begin
      if (dq.size() > 0) begin
        valid_in = 1'b1;
        data_in  = dq.pop_front();
      end else begin
        valid_in = ($urandom_range(99) < p_valid);
        data_in  = 8'($urandom);
      end
    end
    if (rx_low_left > 0) begin
      rx_active = 1'b0;
      rx_low_left--;
    end else begin
      rx_active = 1'b1;
      if ($urandom_range(99) < p_burst) rx_low_left = $urandom_range(12, 3);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive_next();
    end
  endtask

  // Assert reset at the current time, which is never a rising edge. Hold it
  // for n edges, checking reset values, then release it.
  task automatic do_reset(input int n);
    reset_L  = 1'b0;
    valid_in = 1'b0;
    dq.delete();
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < n; i++) begin
      @(posedge clk_32f);
      #1;
      check_outputs();
    end
    reset_L = 1'b1;
  endtask

  initial begin
    bit found;
    reset_L   = 1'b0;
    valid_in  = 1'b0;
    data_in   = 8'h00;
    rx_active = 1'b1;
    #2;

    // startup with no traffic: 4 commas then idle
    do_reset(3);
    p_valid = 0;
    drive_next();
    run(70);

    // pushes during SYNC: A5, 3C, then three more to fill the FIFO
    do_reset(2);
    dq.push_back(8'hA5); dq.push_back(8'h3C); dq.push_back(8'hC3);
    dq.push_back(8'h0F); dq.push_back(8'hF0);
    drive_next();
    run(90);

    // push on a load edge while the FIFO is empty in RUN
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_st == 2 && q.size() == 0 && m_pos == 7 && !valid_in) begin
        found = 1;
        break;
      end
      drive_next();
    end
    chk("find_load_edge", {7'd0, found}, 8'd1);
    dq.push_back(8'h5A);
    drive_next();
    run(24);

    // reset in the middle of a byte while data is flowing
    p_valid = 70;
    drive_next();
    run(30);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_st == 2 && m_pos == 3) begin
        found = 1;
        break;
      end
      drive_next();
    end
    chk("find_mid_byte", {7'd0, found}, 8'd1);
    do_reset(2);
    p_valid = 0;
    drive_next();
    run(60);

    // rx_active dropout in RUN with bytes queued
    dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
    rx_low_left = 10;
    drive_next();
    run(80);

    // long randomized run
    for (int blk = 0; blk < 15; blk++) begin
      p_valid = $urandom_range(100);
      p_burst = $urandom_range(4);
      run(200);
    end
    p_burst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ser_tx_bc.md
# ser_tx_bc

Serial transmit stage of the PHY: accepts parallel bytes from the transmit-side mux through a valid/ready handshake, buffers them in a 4-entry FIFO, and shifts them out MSB-first on a single serial line at clk_32f. After reset it emits a block of 0xBC commas so the receiving serial-to-parallel stage can align on byte boundaries. When no data is pending it emits an idle code. It sits directly upstream of the receive path's flop and serial-to-parallel converter.

## Interface
- Parameters:
  - COMMA, default 8'hBC, sync/alignment symbol.
  - IDLE_CODE, default 8'h7C, symbol sent in RUN when the FIFO is empty.
  - SYNC_COMMAS, default 4, number of commas emitted per sync sequence (≥1).
- Ports:
  - clk_32f  in  1  single clock; all state changes on the rising edge.
  - reset_L  in  1  asynchronous, active-low reset.
  - data_in  in  8  byte to transmit.
  - valid_in  in  1  data_in is valid.
  - ready_out  out  1  block accepts a byte this cycle.
  - rx_active  in  1  receiver-in-sync indication from the far end. Used only with SER_RESYNC_EN.
  - data_out  out  1  serial bit stream.
  - byte_strobe  out  1  high while data_out carries bit 0 of a byte.
  - state_out  out  2  0=RESET, 1=SYNC, 2=RUN.

## Operation
- Push: happens when valid_in && ready_out at a rising edge. ready_out = (state != RESET) && (count < 4). Pushes are accepted in SYNC and RUN.
- Shift register: 8 bits. data_out is shift[7]. The register shifts left by one each cycle, with a 3-bit bit counter bit_cnt running 0..7.
- Load edge: any edge where state == RESET, or bit_cnt == 7. At a load edge the shift register takes the next symbol and bit_cnt becomes 0.
- Next symbol selection:
  - Leaving RESET: COMMA; state → SYNC; sync_cnt → 1.
  - In SYNC with sync_cnt < SYNC_COMMAS: COMMA; sync_cnt increments.
  - In SYNC with sync_cnt == SYNC_COMMAS: state → RUN; load as in RUN.
  - In RUN: the FIFO head if count > 0 (pop); otherwise IDLE_CODE.
- Simultaneous push and pop on the same edge: both take effect and count is unchanged. A byte pushed on a load edge into an empty FIFO is not visible to that load; IDLE_CODE is sent instead.
- FIFO: circular, with 2-bit read and write pointers that wrap 3→0, and a 3-bit count. A full FIFO blocks pushes; an empty FIFO never pops.

## Timing
- Reset values: data_out=0, byte_strobe=0, ready_out=0, state_out=0, shift=0, bit_cnt=0, sync_cnt=0, FIFO empty, pointers=0.
- Reset asserted mid-byte: every output drops to its reset value immediately (asynchronous). The FIFO contents are discarded.
- Startup:
  - First rising edge with reset_L high: loads COMMA. data_out=1 (COMMA bit 7) from that edge onward.
  - byte_strobe is first high 7 cycles later.
  - Bytes are 8 cycles each, back to back, with no gaps.
- Latency: a byte pushed at edge E into an empty FIFO in RUN starts at the first load edge strictly after E, i.e. 1–8 cycles later.
- byte_strobe is registered. It is high exactly in cycles where bit_cnt == 7.

## Configuration
- SER_RESYNC_EN defined:
  - In RUN, a counter tracks consecutive cycles with rx_active == 0. Any cycle with rx_active == 1 clears it.
  - At 8 cycles low a resync flag is set.
  - At the next load edge the block loads COMMA, sets state → SYNC and sync_cnt → 1, and clears the flag and the counter.
  - The FIFO is retained and pushes continue.
- SER_RESYNC_EN undefined: rx_active is ignored and the block never leaves RUN except through reset.

## Test plan
- Reset release, no pushes → data_out carries 4× 0xBC (10111100) then 0x7C repeating. byte_strobe pulses every 8 cycles. state_out goes 0→1→2 at the 5th load edge.
- Push 0xA5 then 0x3C during SYNC → after the 4 commas the serial stream is 10100101, 00111100, then 0x7C repeating.
- Push 5 bytes back-to-back during SYNC → ready_out drops after the 4th is accepted. The 5th is held until the first RUN pop, then accepted. All 5 bytes are emitted in push order.
- Push on a load edge with the FIFO empty in RUN → 0x7C is sent first, then the pushed byte in the following 8-cycle slot.
- reset_L low at bit_cnt == 3 of a data byte → data_out=0 and ready_out=0 immediately. On release, the full 4× 0xBC sequence restarts and the FIFO is empty.
- SER_RESYNC_EN defined, rx_active low for 8 cycles in RUN with 2 bytes queued → at the next byte boundary 4× 0xBC are sent, then the 2 bytes. Same stimulus with the macro undefined → the stream is unaffected.
